// File: rtl/mac_array_ctrl_pkg.sv
// Shared constants and state encoding for the MAC array sequencer.
package mac_array_ctrl_pkg;

    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int ADDR_BW = 11;
    localparam int LEN_BW  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GAP   = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_array_ctrl_phase_counter.sv
// Loadable down-counter; o_tc flags the last cycle of a phase (count == 0).
module phase_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for the weight-stationary MAC array: kernel load, pipeline gap,
// activation stream, then drain until every output vector has been counted.
module mac_array_ctrl
    import mac_array_ctrl_pkg::*;
#(
    parameter int row     = ROW,
    parameter int col     = COL,
    parameter int addr_bw = ADDR_BW,
    parameter int len_bw  = LEN_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic [len_bw-1:0]  nij_len,
    input  logic [col-1:0]     valid,
    output logic               mem_rd,
    output logic [addr_bw-1:0] mem_addr,
    output logic [1:0]         inst_w,
    output logic               out_wr,
    output logic               busy,
    output logic               done,
    output state_t             dbg_state,
    output logic [len_bw-1:0]  dbg_out_cnt
);

    state_t             r_state;
    state_t             w_state_next;
    logic [addr_bw-1:0] r_addr;
    logic [addr_bw-1:0] r_x_base;
    logic [len_bw-1:0]  r_nij_len;
    logic [len_bw-1:0]  r_out_cnt;
    logic [len_bw-1:0]  w_out_cnt_next;
    logic [1:0]         r_inst;
    logic               w_rd;
    logic               w_out_wr;
    logic               w_in_stream;
    logic               w_cnt_load;
    logic [len_bw-1:0]  w_cnt_val;
    logic               w_cnt_en;
    logic               w_cnt_tc;
    logic               w_addr_load;
    logic [addr_bw-1:0] w_addr_val;
    logic               w_unused_valid;

    // Only the last column's valid marks a complete output vector.
    assign w_unused_valid = ^valid[col-2:0];

    phase_counter #(.WIDTH(len_bw)) u_phase_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_tc       (w_cnt_tc)
    );

    assign w_rd           = (r_state == LOAD) || (r_state == EXEC);
    assign w_in_stream    = (r_state == EXEC) || (r_state == DRAIN);
    assign w_out_wr       = valid[col-1] && w_in_stream;
    assign w_out_cnt_next = r_out_cnt + len_bw'(w_out_wr);

    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_val    = '0;
        w_cnt_en     = 1'b0;
        w_addr_load  = 1'b0;
        w_addr_val   = r_addr;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = LOAD;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = len_bw'(row - 1);
                    w_addr_load  = 1'b1;
                    w_addr_val   = w_base;
                end
            end
            LOAD: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_state_next = GAP;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = len_bw'(row + col - 1);
                end
            end
            GAP: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_addr_load = 1'b1;
                    w_addr_val  = r_x_base;
                    if (r_nij_len == '0) begin
                        w_state_next = DRAIN;
                    end else begin
                        w_state_next = EXEC;
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = r_nij_len - len_bw'(1);
                    end
                end
            end
            EXEC: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Count the pulse arriving this cycle so done follows the last output directly.
                if ((r_nij_len == '0) || (w_out_cnt_next == r_nij_len)) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_x_base  <= '0;
            r_nij_len <= '0;
            r_out_cnt <= '0;
            r_inst    <= INST_IDLE;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && start) begin
                r_x_base  <= x_base;
                r_nij_len <= nij_len;
            end
            if (w_addr_load) begin
                r_addr <= w_addr_val;
            end else if (w_rd) begin
                r_addr <= r_addr + addr_bw'(1);
            end
            r_out_cnt <= w_in_stream ? w_out_cnt_next : '0;
            // Instruction trails the read by one cycle to line up with SRAM data.
            if (r_state == LOAD) begin
                r_inst <= INST_LOAD;
            end else if (r_state == EXEC) begin
                r_inst <= INST_EXEC;
            end else begin
                r_inst <= INST_IDLE;
            end
        end
    end

    assign mem_rd      = w_rd;
    assign mem_addr    = r_addr;
    assign inst_w      = r_inst;
    assign out_wr      = w_out_wr;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign dbg_state   = r_state;
    assign dbg_out_cnt = r_out_cnt;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: read-port scoreboard plus per-scenario tile checks.
module tb_mac_array_ctrl;
    import mac_array_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [ADDR_BW-1:0] w_base;
    logic [ADDR_BW-1:0] x_base;
    logic [LEN_BW-1:0]  nij_len;
    logic [COL-1:0]     valid;
    logic               mem_rd;
    logic [ADDR_BW-1:0] mem_addr;
    logic [1:0]         inst_w;
    logic               out_wr;
    logic               busy;
    logic               done;
    state_t             dbg_state;
    logic [LEN_BW-1:0]  dbg_out_cnt;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {expected idle gap before the read (FF = unchecked), inst, addr}.
    logic [20:0]        exp_q[$];
    logic [20:0]        item;
    logic               prev_rd = 1'b0;
    logic [ADDR_BW-1:0] prev_addr = '0;
    int                 idle_run = 0;
    int                 prev_gap = 0;
    int                 out_wr_cnt = 0;
    int                 done_cnt = 0;
    bit                 seen_exec = 1'b0;

    mac_array_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_base      (w_base),
        .x_base      (x_base),
        .nij_len     (nij_len),
        .valid       (valid),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .inst_w      (inst_w),
        .out_wr      (out_wr),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state),
        .dbg_out_cnt (dbg_out_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            prev_rd  = 1'b0;
            idle_run = 0;
            exp_q.delete();
        end else begin
            if (prev_rd) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: addr=%h inst=%b, required no read", prev_addr, inst_w);
                end else begin
                    item = exp_q.pop_front();
                    if ({inst_w, prev_addr} !== item[12:0]) begin
                        errors++;
                        $display("FAIL read_seq: inst=%b addr=%h, required inst=%b addr=%h",
                                 inst_w, prev_addr, item[12:11], item[10:0]);
                    end
                    if (item[20:13] != 8'hFF) begin
                        checks++;
                        if (prev_gap != int'(item[20:13])) begin
                            errors++;
                            $display("FAIL read_gap: idle=%0d, required %0d", prev_gap, item[20:13]);
                        end
                    end
                end
            end else begin
                checks++;
                if (inst_w !== INST_IDLE) begin
                    errors++;
                    $display("FAIL inst_no_read: inst=%b, required 00", inst_w);
                end
            end
            if (out_wr === 1'b1) out_wr_cnt++;
            if (done === 1'b1) done_cnt++;
            if (dbg_state == EXEC) seen_exec = 1'b1;
            if (mem_rd) begin
                prev_gap = idle_run;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            prev_rd   = mem_rd;
            prev_addr = mem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input logic [ADDR_BW-1:0] wb, input logic [ADDR_BW-1:0] xb, input int n);
        logic [ADDR_BW-1:0] a;
        for (int k = 0; k < ROW; k++) begin
            a = wb + ADDR_BW'(k);
            exp_q.push_back({(k == 0) ? 8'hFF : 8'h00, INST_LOAD, a});
        end
        for (int i = 0; i < n; i++) begin
            a = xb + ADDR_BW'(i);
            exp_q.push_back({(i == 0) ? 8'(ROW + COL) : 8'h00, INST_EXEC, a});
        end
    endtask

    task automatic start_tile(input logic [ADDR_BW-1:0] wb, input logic [ADDR_BW-1:0] xb, input int n);
        push_tile(wb, xb, n);
        out_wr_cnt = 0;
        done_cnt   = 0;
        seen_exec  = 1'b0;
        w_base     = wb;
        x_base     = xb;
        nij_len    = LEN_BW'(n);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int budget);
        int c = 0;
        while (dbg_state !== s && c < budget) begin
            tick();
            c++;
        end
        checks++;
        if (dbg_state !== s) begin
            errors++;
            $display("FAIL wait_state: state=%0d, required %0d within %0d cycles", dbg_state, s, budget);
        end
    endtask

    task automatic check_end(input string name, input int n);
        checks++;
        if (out_wr_cnt != n) begin
            errors++;
            $display("FAIL %s_out_wr_count: got %0d, required %0d", name, out_wr_cnt, n);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_reads_missing: %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Full tile with n > 0 output vectors returned one per pulse in DRAIN.
    task automatic run_tile(input string name, input logic [ADDR_BW-1:0] wb,
                            input logic [ADDR_BW-1:0] xb, input int n);
        start_tile(wb, xb, n);
        wait_state(DRAIN, 400);
        for (int i = 0; i < n; i++) begin
            valid = 8'h80;
            tick();
            valid = '0;
            if (i < n - 1) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early_done: done=%b after %0d outputs, required 0", name, done, i + 1);
                end
                tick();
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b busy=%b, required 1 1", name, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b, required 0 0", name, done, busy);
        end
        check_end(name, n);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        valid   = '0;
        w_base  = '0;
        x_base  = '0;
        nij_len = '0;
        tick();
        tick();
        checks++;
        if (mem_rd !== 1'b0 || mem_addr !== '0 || inst_w !== 2'b00) begin
            errors++;
            $display("FAIL reset_read_port: rd=%b addr=%h inst=%b, required 0 000 00", mem_rd, mem_addr, inst_w);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b out_wr=%b, required 0 0 0", busy, done, out_wr);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (dbg_state !== IDLE || dbg_out_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d out_cnt=%0d, required 0 0", dbg_state, dbg_out_cnt);
        end
    endtask

    task automatic test_basic_tile();
        run_tile("basic", 11'h010, 11'h100, 4);
    endtask

    task automatic test_zero_len();
        int c = 0;
        start_tile(11'h020, 11'h300, 0);
        while (done !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
        checks++;
        if (c != ROW + ROW + COL + 1) begin
            errors++;
            $display("FAIL zero_len_latency: done after %0d cycles, required %0d", c, ROW + ROW + COL + 1);
        end
        checks++;
        if (seen_exec) begin
            errors++;
            $display("FAIL zero_len_exec: EXEC entered=1, required 0");
        end
        tick();
        check_end("zero_len", 0);
    endtask

    task automatic test_extra_start();
        start_tile(11'h040, 11'h200, 6);
        wait_state(EXEC, 100);
        for (int i = 0; i < 3; i++) begin
            w_base  = 11'h555;
            x_base  = 11'h666;
            nij_len = 8'd1;
            start   = 1'b1;
            tick();
            start   = 1'b0;
            tick();
        end
        wait_state(DRAIN, 20);
        valid = 8'h80;
        for (int i = 0; i < 6; i++) tick();
        valid = '0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL extra_start_done: done=%b, required 1", done);
        end
        tick();
        check_end("extra_start", 6);
        valid = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_wr !== 1'b0 || dbg_out_cnt !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: out_wr=%b out_cnt=%0d busy=%b, required 0 0 0",
                         out_wr, dbg_out_cnt, busy);
            end
        end
        valid = '0;
    endtask

    task automatic test_wrap();
        run_tile("wrap", 11'h7FC, 11'h7FE, 4);
    endtask

    task automatic test_reset_mid();
        start_tile(11'h000, 11'h050, 8);
        wait_state(EXEC, 100);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (mem_rd !== 1'b0 || inst_w !== 2'b00 || busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid: rd=%b inst=%b busy=%b state=%0d, required 0 00 0 0",
                     mem_rd, inst_w, busy, dbg_state);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid_done: %0d done pulses, required 0", done_cnt);
        end
        run_tile("after_reset", 11'h0A0, 11'h0C0, 3);
    endtask

    initial begin
        test_reset();
        test_basic_tile();
        test_zero_len();
        test_extra_start();
        test_wrap();
        test_reset_mid();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
